pong_frame_sequencer: RTL

Frame-rate controller that sequences the PingPong compute datapath. Once per frame it fetches paddle controller bits from the shared DPRAM, issues a single-cycle compute enable and samples the point event. It also runs the serve/score/game-over flow: it holds the compute block in reset between rallies and keeps the match score. It sits between the DPRAM read port and the compute top, replacing its free-running enable.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/pong_frame_timer.sv | 27 ++
 rtl/pong_frame_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the PingPong frame sequencer.
//   state_t         : sequencer FSM encoding (OVER is IDLE plus gameOver)
//   CTRL_UP/DOWN    : bit positions inside one 2-bit paddle command
//   POINT_LEFT/RIGHT: bit positions inside pointEvent / winner
//   sat_inc8        : saturating 8-bit increment used for the scores
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    FETCH = 3'd3,
    WAIT  = 3'd4,
    STEP  = 3'd5,
    CHECK = 3'd6,
    POINT = 3'd7
  } state_t;

  localparam int CTRL_UP     = 0;
  localparam int CTRL_DOWN   = 1;

  localparam int POINT_RIGHT = 0;
  localparam int POINT_LEFT  = 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer: free-running frame divider.
//   clk, rst      : clock, asynchronous active-high reset
//   frame_tick_o  : high for one cycle when the counter reaches FRAME_DIV-1
// The counter runs in every FSM state; the first tick after reset release
// arrives FRAME_DIV-1 edges later.
module pong_frame_timer #(
  parameter logic [15:0] FRAME_DIV = 16'd833
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick_o
);

  logic [15:0] count_q, count_d;

  assign frame_tick_o = (count_q == FRAME_DIV - 16'd1);

  always_comb begin
    count_d = frame_tick_o ? 16'd0 : count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 16'd0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/pong_frame_sequencer.sv
// pong_frame_sequencer: frame-rate controller for the PingPong compute block.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begins a match from IDLE / OVER (ignored elsewhere)
//   rdData          : DPRAM read data, valid one cycle after rdEn
//   pointEvent      : compute point flags, valid one cycle after computeEn
//   rdEn, rdAddr    : DPRAM read strobe and (constant) address
//   computeEn       : one-cycle compute step enable
//   computeRst      : holds compute at defaults in IDLE / SERVE
//   left/rightPaddleCmd : latched controller bits {down,up}
//   left/rightScore : match score
//   gameOver, winner: match result ({left,right}; both set on a tie)
//   state           : FSM state for debug
// Handshake: rdEn is a single-cycle strobe with fixed one-cycle read
// latency; computeEn is a single-cycle strobe with fixed one-cycle result
// latency. There is no back-pressure on either side.
module pong_frame_sequencer
  import pong_pkg::*;
#(
  parameter logic [15:0]       FRAME_DIV    = 16'd833,
  parameter logic [7:0]        SERVE_FRAMES = 8'd60,
  parameter logic [7:0]        WIN_SCORE    = 8'd11,
  parameter int                ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDRESS = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rdData,
  input  logic [1:0]        pointEvent,
  output logic              rdEn,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              computeEn,
  output logic              computeRst,
  output logic [1:0]        leftPaddleCmd,
  output logic [1:0]        rightPaddleCmd,
  output logic [7:0]        leftScore,
  output logic [7:0]        rightScore,
  output logic              gameOver,
  output logic [1:0]        winner,
  output logic [2:0]        state
);

  logic   frame_tick;
  state_t state_q, state_d;

  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic       rd_en_q, rd_en_d;
  logic       compute_en_q, compute_en_d;
  logic       compute_rst_q, compute_rst_d;
  logic [1:0] left_cmd_q, left_cmd_d;
  logic [1:0] right_cmd_q, right_cmd_d;
  logic [7:0] left_score_q, left_score_d;
  logic [7:0] right_score_q, right_score_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;

  logic serve_done;
  logic left_won, right_won;

  // Upper data bits carry nothing for this block.
  logic unused_rd_bits;
  assign unused_rd_bits = ^rdData[7:4];

  pong_frame_timer #(
    .FRAME_DIV(FRAME_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .frame_tick_o(frame_tick)
  );

  assign serve_done = frame_tick && (serve_cnt_q == SERVE_FRAMES - 8'd1);
  assign left_won   = (left_score_q  == WIN_SCORE);
  assign right_won  = (right_score_q == WIN_SCORE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Ticks outside PLAY/SERVE are simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = SERVE;
      SERVE:   if (serve_done) state_d = PLAY;
      PLAY:    if (frame_tick) state_d = FETCH;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = STEP;
      STEP:    state_d = CHECK;
      CHECK:   state_d = (pointEvent != 2'b00) ? POINT : PLAY;
      POINT:   state_d = (left_won || right_won) ? IDLE : SERVE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. Strobes are decoded from state_d so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    rd_en_d       = (state_d == FETCH);
    compute_en_d  = (state_d == STEP);
    compute_rst_d = (state_d == IDLE) || (state_d == SERVE);

    serve_cnt_d   = serve_cnt_q;
    left_cmd_d    = left_cmd_q;
    right_cmd_d   = right_cmd_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;

    if (state_q == SERVE && frame_tick) begin
      serve_cnt_d = serve_done ? 8'd0 : serve_cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          left_score_d  = 8'd0;
          right_score_d = 8'd0;
          game_over_d   = 1'b0;
          winner_d      = 2'b00;
        end
      end
      WAIT: begin
        left_cmd_d  = {rdData[CTRL_DOWN],     rdData[CTRL_UP]};
        right_cmd_d = {rdData[2 + CTRL_DOWN], rdData[2 + CTRL_UP]};
      end
      CHECK: begin
        if (pointEvent[POINT_LEFT])  left_score_d  = sat_inc8(left_score_q);
        if (pointEvent[POINT_RIGHT]) right_score_d = sat_inc8(right_score_q);
      end
      POINT: begin
        if (left_won || right_won) begin
          game_over_d           = 1'b1;
          winner_d[POINT_LEFT]  = left_won;
          winner_d[POINT_RIGHT] = right_won;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serve_cnt_q   <= 8'd0;
      rd_en_q       <= 1'b0;
      compute_en_q  <= 1'b0;
      compute_rst_q <= 1'b1;
      left_cmd_q    <= 2'b00;
      right_cmd_q   <= 2'b00;
      left_score_q  <= 8'd0;
      right_score_q <= 8'd0;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
    end else begin
      serve_cnt_q   <= serve_cnt_d;
      rd_en_q       <= rd_en_d;
      compute_en_q  <= compute_en_d;
      compute_rst_q <= compute_rst_d;
      left_cmd_q    <= left_cmd_d;
      right_cmd_q   <= right_cmd_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  assign rdAddr         = BASE_ADDRESS;
  assign rdEn           = rd_en_q;
  assign computeEn      = compute_en_q;
  assign computeRst     = compute_rst_q;
  assign leftPaddleCmd  = left_cmd_q;
  assign rightPaddleCmd = right_cmd_q;
  assign leftScore      = left_score_q;
  assign rightScore     = right_score_q;
  assign gameOver       = game_over_q;
  assign winner         = winner_q;
  assign state          = state_q;

endmodule
